// File: rtl/byte_word_loader_if.sv
// byte_word_loader_if: byte-side handshake and memory write port of the loader.
// Optional macro LOADER_CHECKSUM_EN adds the checksum signal.
`timescale 1ns/1ps
interface byte_word_loader_if #(
  parameter int ADDR_W = 5
);
  logic              load_en;
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        checksum;

  modport master (
    output load_en, byte_valid, byte_in,
    input  byte_ready, wr_en, wr_addr, wr_data, word_count, full, overflow, checksum
  );

  modport slave (
    input  load_en, byte_valid, byte_in,
    output byte_ready, wr_en, wr_addr, wr_data, word_count, full, overflow, checksum
  );
`else
  modport master (
    output load_en, byte_valid, byte_in,
    input  byte_ready, wr_en, wr_addr, wr_data, word_count, full, overflow
  );

  modport slave (
    input  load_en, byte_valid, byte_in,
    output byte_ready, wr_en, wr_addr, wr_data, word_count, full, overflow
  );
`endif
endinterface

// File: rtl/byte_word_loader.sv
// byte_word_loader: packs a byte stream into 32-bit words (byte 0 -> bits [7:0])
// and writes them to word-addressed memory at an auto-incrementing address.
// Optional macro LOADER_CHECKSUM_EN adds a running XOR of accepted bytes.
`timescale 1ns/1ps
module byte_word_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic               clk,
  input  logic               rst,
  byte_word_loader_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT   = 1;
  localparam logic [ADDR_W-1:0] ONE_ADDR  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT,
    S_FULL
  } state_t;

  state_t            state;
  logic [1:0]        idx;
  logic [23:0]       assembly;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   word_count_q;
  logic              byte_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              full_q;
  logic              overflow_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        checksum_q;
`endif

  // Session FSM: byte collection, one-cycle commit, and full/overflow tracking.
  // Byte 3 never lands in the assembly register; it goes straight into wr_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      assembly     <= '0;
      addr_cnt     <= '0;
      word_count_q <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load_en) begin
            state        <= S_COLLECT;
            byte_ready_q <= 1'b1;
            idx          <= '0;
            addr_cnt     <= '0;
            word_count_q <= '0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
          end
        end
        S_COLLECT: begin
`ifdef LOADER_CHECKSUM_EN
          if (bus.byte_valid) begin
            checksum_q <= checksum_q ^ bus.byte_in;
          end
`endif
          if (!bus.load_en) begin
            state        <= S_IDLE;
            byte_ready_q <= 1'b0;
            idx          <= '0;
          end else if (bus.byte_valid) begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0: assembly[7:0]   <= bus.byte_in;
              2'd1: assembly[15:8]  <= bus.byte_in;
              2'd2: assembly[23:16] <= bus.byte_in;
              default: begin
                state        <= S_COMMIT;
                byte_ready_q <= 1'b0;
                wr_en_q      <= 1'b1;
                wr_addr_q    <= addr_cnt;
                wr_data_q    <= {bus.byte_in, assembly};
              end
            endcase
          end
        end
        S_COMMIT: begin
          word_count_q <= word_count_q + ONE_CNT;
          if ((word_count_q + ONE_CNT) == DEPTH_CNT) begin
            state  <= S_FULL;
            full_q <= 1'b1;
          end else begin
            addr_cnt <= addr_cnt + ONE_ADDR;
            if (bus.load_en) begin
              state        <= S_COLLECT;
              byte_ready_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_FULL: begin
          if (bus.byte_valid) begin
            overflow_q <= 1'b1;
          end
          if (!bus.load_en) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state        <= S_IDLE;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.word_count = word_count_q;
  assign bus.full       = full_q;
  assign bus.overflow   = overflow_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_byte_word_loader.sv
// tb_byte_word_loader: directed vectors with a write scoreboard for byte_word_loader.
// Honours LOADER_CHECKSUM_EN when the design is built with it.
`timescale 1ns/1ps
module tb_byte_word_loader;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } write_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  write_t sb[$];

  byte_word_loader_if #(.ADDR_W(5)) bus ();

  byte_word_loader #(.ADDR_W(5), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Offers one byte and holds it until the loader takes it (bounded wait).
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (guard < 20) begin
      @(negedge clk);
      if (bus.byte_ready) break;
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte_accept_timeout: byte 0x%02h not accepted, expected acceptance within 20 cycles", b);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic startSession();
    bus.load_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic endSession();
    bus.load_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    write_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    write_t w;
    if (!rst && bus.wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: addr 0x%02h data 0x%08h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        w = sb.pop_front();
        checkOutput("wr_addr", 32'(bus.wr_addr), 32'(w.addr));
        checkOutput("wr_data", bus.wr_data, w.data);
        checkOutput("ready_during_commit", 32'(bus.byte_ready), 32'd0);
      end
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.load_en    = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;

    // Reset state
    #12;
    checkOutput("reset_byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("reset_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("reset_wr_data", bus.wr_data, 32'd0);
    checkOutput("reset_word_count", 32'(bus.word_count), 32'd0);
    checkOutput("reset_full", 32'(bus.full), 32'd0);
    checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic word
    $display("[TB] basic word");
    startSession();
    checkOutput("collect_byte_ready", 32'(bus.byte_ready), 32'd1);
    expectWrite(5'd0, 32'h44332211);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("checksum_after_word", 32'(bus.checksum), 32'h44);
`endif
    @(posedge clk);
    #1;
    checkOutput("word_count_after_first", 32'(bus.word_count), 32'd1);
    endSession();
    checkOutput("word_count_held_idle", 32'(bus.word_count), 32'd1);

    // Partial word discarded, lanes realigned
    $display("[TB] partial word discard");
    startSession();
`ifdef LOADER_CHECKSUM_EN
    checkOutput("checksum_session_clear", 32'(bus.checksum), 32'h00);
`endif
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    endSession();
    checkOutput("word_count_after_discard", 32'(bus.word_count), 32'd0);
    startSession();
    expectWrite(5'd0, 32'h04030201);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    endSession();

    // Byte held through commit is not taken
    $display("[TB] byte during commit");
    startSession();
    expectWrite(5'd0, 32'h40302010);
    expectWrite(5'd1, 32'h80706050);
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h30);
    applyStimulus(8'h40);
    bus.byte_in    = 8'hEE;
    bus.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    applyStimulus(8'h50);
    applyStimulus(8'h60);
    applyStimulus(8'h70);
    applyStimulus(8'h80);
    endSession();
    checkOutput("word_count_two", 32'(bus.word_count), 32'd2);

    // Asynchronous reset mid-word
    $display("[TB] async reset");
    startSession();
    expectWrite(5'd0, 32'hEFBEADDE);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    applyStimulus(8'hBE);
    applyStimulus(8'hEF);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_wr_data", bus.wr_data, 32'd0);
    checkOutput("async_rst_word_count", 32'(bus.word_count), 32'd0);
    checkOutput("async_rst_byte_ready", 32'(bus.byte_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("async_rst_checksum", 32'(bus.checksum), 32'd0);
`endif
    bus.load_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    startSession();
    expectWrite(5'd0, 32'h0D0C0B0A);
    applyStimulus(8'h0A);
    applyStimulus(8'h0B);
    applyStimulus(8'h0C);
    applyStimulus(8'h0D);
    endSession();

    // Fill all 32 words, then overflow
    $display("[TB] fill to full");
    startSession();
    for (int i = 0; i < 32; i++) begin
      expectWrite(5'(i), 32'(i));
      applyStimulus(8'(i));
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
    end
    @(posedge clk);
    #1;
    checkOutput("full_set", 32'(bus.full), 32'd1);
    checkOutput("full_word_count", 32'(bus.word_count), 32'd32);
    checkOutput("full_byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("overflow_before", 32'(bus.overflow), 32'd0);
    bus.byte_in    = 8'h99;
    bus.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    checkOutput("overflow_set", 32'(bus.overflow), 32'd1);
    checkOutput("overflow_byte_ready", 32'(bus.byte_ready), 32'd0);
    endSession();
    checkOutput("full_held_idle", 32'(bus.full), 32'd1);
    checkOutput("overflow_held_idle", 32'(bus.overflow), 32'd1);
    checkOutput("count_held_idle", 32'(bus.word_count), 32'd32);
    startSession();
    checkOutput("full_cleared", 32'(bus.full), 32'd0);
    checkOutput("overflow_cleared", 32'(bus.overflow), 32'd0);
    checkOutput("count_cleared", 32'(bus.word_count), 32'd0);
    endSession();

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
